// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2^2 SDF stage-pair sequencer.
package fft_pkg;

   localparam int DW = 11;

   typedef struct packed {
      logic signed [DW-1:0] re;
      logic signed [DW-1:0] im;
   } cplx_t;

   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

   // Quadrant index to twiddle multiplier k: 00->0, 01->2, 10->1, 11->3.
   function automatic logic [1:0] bitrev2(input logic [1:0] b);
      return {b[0], b[1]};
   endfunction

   // Two's complement negate that maps the most negative value to the most positive.
   function automatic logic signed [DW-1:0] sat_neg(input logic signed [DW-1:0] x);
      return (x == {1'b1, {(DW-1){1'b0}}}) ? ~x : -x;
   endfunction

endpackage

// File: rtl/fft_neg_j_rot.sv
// Combinational multiply by -j with saturation: re' = im, im' = -re.
module fft_neg_j_rot
   import fft_pkg::*;
(
   input  cplx_t din,
   output cplx_t dout
);

   assign dout = {din.im, sat_neg(din.re)};

endmodule

// File: rtl/fft_r22_stage_ctrl.sv
// Sample sequencer for one R2^2 SDF stage pair: frame counter, BF1/BF2 selects,
// twiddle address and in-line -j rotation, all registered one cycle after accept.
module fft_r22_stage_ctrl #(
   parameter int LOG2N = 6,
   parameter int DW    = 11   // must equal fft_pkg::DW (rotator works on cplx_t)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic                in_sop,
   input  logic [2*DW-1:0]     in_data,
   output logic                out_valid,
   output logic                out_sop,
   output logic [2*DW-1:0]     out_data,
   output logic                bf1_sel,
   output logic                bf2_sel,
   output logic                jrot,
   output logic [LOG2N-1:0]    tw_addr,
   output logic                err_sop
);
   import fft_pkg::*;

   localparam logic [LOG2N:0] FILL_LAST = (LOG2N+1)'((1 << LOG2N) - 1);
   localparam logic [LOG2N:0] FILL_ONE  = (LOG2N+1)'(1);

   state_t           state, state_nx;
   logic [LOG2N-1:0] cnt, cnt_nx, c;
   logic [LOG2N:0]   fill, fill_nx;
   logic             accept, sop_err, restart, c_jrot;
   logic [LOG2N-1:0] k_ext, m_ext, tw;
   logic [2*DW-1:0]  rot_data;

   fft_neg_j_rot u_rot (
      .din  (in_data),
      .dout (rot_data)
   );

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      fill_nx  = fill;
      c        = cnt;
      accept   = (state == IDLE) ? (in_valid & in_sop) : in_valid;
      sop_err  = accept && (state != IDLE) && in_sop && (cnt != '0);
      restart  = accept && ((state == IDLE) || sop_err);
      if (restart) c = '0;
      if (accept) begin
         cnt_nx = c + 1'b1;
         if (restart) begin
            fill_nx  = FILL_ONE;
            state_nx = FILL;
         end else if (state == FILL) begin
            fill_nx = fill + 1'b1;
            if (fill == FILL_LAST) state_nx = RUN;
         end
      end
   end

   // Twiddle exponent k*m fits in LOG2N bits after truncation, which is the mod N.
   always_comb begin
      c_jrot = (c[LOG2N-1 -: 2] == 2'b11);
      k_ext  = {{(LOG2N-2){1'b0}}, bitrev2(c[LOG2N-1 -: 2])};
      m_ext  = {2'b00, c[LOG2N-3:0]};
      tw     = k_ext * m_ext;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         fill  <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         fill  <= fill_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         err_sop   <= 1'b0;
         out_data  <= '0;
         bf1_sel   <= 1'b0;
         bf2_sel   <= 1'b0;
         jrot      <= 1'b0;
         tw_addr   <= '0;
      end else begin
         out_valid <= accept && (state == RUN) && !restart;
         out_sop   <= accept && (state == RUN) && !restart && (c == '0);
         err_sop   <= sop_err;
         if (accept) begin
            out_data <= c_jrot ? rot_data : in_data;
            bf1_sel  <= c[LOG2N-1];
            bf2_sel  <= c[LOG2N-2];
            jrot     <= c_jrot;
            tw_addr  <= tw;
         end
      end
   end

endmodule

// File: tb/tb_fft_r22_stage_ctrl.sv
// Randomized bench for fft_r22_stage_ctrl with an index-arithmetic reference model.
module tb_fft_r22_stage_ctrl;

   localparam int LOG2N = 3;
   localparam int N     = 8;
   localparam int Q     = N / 4;
   localparam int DW    = 11;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_sop = 1'b0;
   logic [2*DW-1:0]  in_data = '0;
   logic             out_valid, out_sop, bf1_sel, bf2_sel, jrot, err_sop;
   logic [2*DW-1:0]  out_data;
   logic [LOG2N-1:0] tw_addr;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: phase 0 idle, 1 filling, 2 running; idx is the next sample index.
   int m_phase, m_idx, m_fill;
   logic             e_valid, e_sop, e_err, e_bf1, e_bf2, e_jrot;
   logic [2*DW-1:0]  e_data;
   logic [LOG2N-1:0] e_tw;
   int tw_seq [8] = '{0, 0, 0, 2, 0, 1, 0, 3};

   always #5 clk = ~clk;

   fft_r22_stage_ctrl #(.LOG2N(LOG2N), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_sop    (in_sop),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_sop   (out_sop),
      .out_data  (out_data),
      .bf1_sel   (bf1_sel),
      .bf2_sel   (bf2_sel),
      .jrot      (jrot),
      .tw_addr   (tw_addr),
      .err_sop   (err_sop)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_idx = 0; m_fill = 0;
      e_valid = 0; e_sop = 0; e_err = 0; e_bf1 = 0; e_bf2 = 0; e_jrot = 0;
      e_data = '0; e_tw = '0;
   endtask

   task automatic model_accept(input logic v, input logic sop, input logic [2*DW-1:0] d);
      int c, q, k, re, im, nre, nim;
      e_valid = 0; e_sop = 0; e_err = 0;
      if (!v || (m_phase == 0 && !sop)) return;
      if (m_phase != 0 && sop && m_idx != 0) e_err = 1;
      if (m_phase == 0 || e_err) begin
         c = 0; m_phase = 1; m_fill = 0;
      end else c = m_idx;
      e_valid = (m_phase == 2);
      e_sop   = e_valid && (c == 0);
      q  = c / Q;
      k  = (q == 1) ? 2 : (q == 2) ? 1 : q;
      re = $signed(d[2*DW-1:DW]);
      im = $signed(d[DW-1:0]);
      if (q == 3) begin
         nre = im;
         nim = -re;
         if (nim > 1023) nim = 1023;
      end else begin
         nre = re; nim = im;
      end
      e_data = {11'(nre), 11'(nim)};
      e_jrot = (q == 3);
      e_bf1  = (c >= N / 2);
      e_bf2  = (q % 2) == 1;
      e_tw   = 3'((k * (c % Q)) % N);
      m_fill++;
      if (m_phase == 1 && m_fill == N) m_phase = 2;
      m_idx = (c + 1) % N;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
      check({tag, ".out_sop"},   32'(out_sop),   32'(e_sop));
      check({tag, ".err_sop"},   32'(err_sop),   32'(e_err));
      check({tag, ".out_data"},  32'(out_data),  32'(e_data));
      check({tag, ".bf1_sel"},   32'(bf1_sel),   32'(e_bf1));
      check({tag, ".bf2_sel"},   32'(bf2_sel),   32'(e_bf2));
      check({tag, ".jrot"},      32'(jrot),      32'(e_jrot));
      check({tag, ".tw_addr"},   32'(tw_addr),   32'(e_tw));
   endtask

   task automatic step(input logic v, input logic sop, input logic [2*DW-1:0] d, input string tag);
      in_valid = v; in_sop = sop; in_data = d;
      model_accept(v, sop, d);
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   function automatic logic [2*DW-1:0] rnd();
      return 22'($urandom);
   endfunction

   initial begin
      logic [2*DW-1:0] d;
      int gpos [3];

      // 1. Reset with random inputs, then ignored samples in IDLE.
      model_reset();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'($urandom); in_sop = 1'($urandom); in_data = rnd();
         @(posedge clk); #1;
         check_outputs("t1_reset");
      end
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rnd(), "t1_idle");

      // 2. Three continuous frames.
      for (int f = 0; f < 3; f++)
         for (int i = 0; i < N; i++) begin
            step(1'b1, i == 0, rnd(), "t2");
            check("t2_tw_seq", 32'(tw_addr), 32'(tw_seq[i]));
         end

      // 3. Directed rotation values on the jrot samples.
      for (int i = 0; i < N; i++) begin
         d = (i == 6) ? {11'sd100, -11'sd37} : (i == 7) ? {-11'sd1024, 11'sd5} : rnd();
         step(1'b1, i == 0, d, "t3");
         if (i == 6) check("t3_rot", 32'(out_data), 32'({-11'sd37, -11'sd100}));
         if (i == 7) check("t3_sat", 32'(out_data), 32'({11'sd5, 11'sd1023}));
      end

      // 4. Stall cycles at random positions inside a running frame.
      for (int g = 0; g < 3; g++) gpos[g] = $urandom_range(1, N - 1);
      for (int i = 0; i < N; i++) begin
         for (int g = 0; g < 3; g++)
            if (gpos[g] == i) begin
               step(1'b0, 1'($urandom), rnd(), "t4_gap");
               check("t4_gap_valid", 32'(out_valid), 32'd0);
            end
         step(1'b1, i == 0, rnd(), "t4");
         check("t4_tw_seq", 32'(tw_addr), 32'(tw_seq[i]));
      end

      // 5. Early start of frame at index 5.
      for (int i = 0; i < 5; i++) step(1'b1, i == 0, rnd(), "t5_pre");
      step(1'b1, 1'b1, rnd(), "t5_early");
      check("t5_err_pulse", 32'(err_sop), 32'd1);
      for (int i = 0; i < N - 1; i++) begin
         step(1'b1, 1'b0, rnd(), "t5_fill");
         check("t5_fill_valid", 32'(out_valid), 32'd0);
      end
      for (int i = 0; i < N; i++) begin
         step(1'b1, i == 0, rnd(), "t5_run");
         if (i == 0) check("t5_resync_sop", 32'(out_sop), 32'd1);
      end

      // 6. Asynchronous reset mid-frame, then a clean restart.
      for (int i = 0; i < 5; i++) step(1'b1, i == 0, rnd(), "t6_pre");
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("t6_async_valid", 32'(out_valid), 32'd0);
      check("t6_async_data",  32'(out_data),  32'd0);
      check("t6_async_tw",    32'(tw_addr),   32'd0);
      check("t6_async_bf1",   32'(bf1_sel),   32'd0);
      check_outputs("t6_async");
      @(negedge clk); @(negedge clk) rst_n = 1'b1;
      step(1'b1, 1'b0, rnd(), "t6_no_sop");
      for (int f = 0; f < 2; f++)
         for (int i = 0; i < N; i++) begin
            step(1'b1, i == 0, rnd(), "t6");
            check("t6_tw_seq", 32'(tw_addr), 32'(tw_seq[i]));
            check("t6_valid", 32'(out_valid), 32'(f == 1));
         end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
